// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file host arbiter: widths, FSM encodings
// and the latched host transaction record.
package regfile_arb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOST  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     wdata;
   } host_txn_t;

   // Bits needed to hold max_val; never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/regfile_host_arbiter_if.sv
// Test/debug host transaction channel into the register-file arbiter.
interface regfile_host_arbiter_if;
   import regfile_arb_pkg::*;

   logic                  host_req;
   logic                  host_we;
   logic [REG_ADDR_W-1:0] host_reg;
   logic [DATA_W-1:0]     host_wdata;
   logic                  host_ack;
   logic [DATA_W-1:0]     host_rdata;

   modport master (output host_req, host_we, host_reg, host_wdata,
                   input  host_ack, host_rdata);
   modport slave  (input  host_req, host_we, host_reg, host_wdata,
                   output host_ack, host_rdata);
endinterface

// File: rtl/regfile_host_arbiter_share_counter.sv
// Core ownership window counter: loads on host completion, counts down to zero
// while the core owns the register file.
module core_share_counter #(
   parameter int LOAD_VAL = 4,
   parameter int CNT_W    = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [CNT_W-1:0] count_r;

   assign zero = (count_r == {CNT_W{1'b0}});

   // Load has priority; the decrement saturates at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= CNT_W'(LOAD_VAL);
      end else if (dec && !zero) begin
         count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/regfile_host_arbiter.sv
// Shares one register-file port between the processor core and a debug host:
// the core is stalled for a drain cycle and a host access cycle per transaction.
module regfile_host_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int MIN_CORE_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   regfile_host_arbiter_if.slave hif,
   input  logic                  core_we,
   input  logic [REG_ADDR_W-1:0] core_wreg,
   input  logic [DATA_W-1:0]     core_wdata,
   input  logic [REG_ADDR_W-1:0] core_rregA,
   input  logic [REG_ADDR_W-1:0] core_rregB,
   output logic [DATA_W-1:0]     core_rdataA,
   output logic [DATA_W-1:0]     core_rdataB,
   output logic                  core_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wreg,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [REG_ADDR_W-1:0] rf_rregA,
   output logic [REG_ADDR_W-1:0] rf_rregB,
   input  logic [DATA_W-1:0]     rf_rdataA,
   input  logic [DATA_W-1:0]     rf_rdataB
);

   localparam int CNT_W = cnt_width(MIN_CORE_CYCLES);

   logic [1:0]        state_r;
   logic [1:0]        state_nx_s;
   host_txn_t         txn_r;
   logic [DATA_W-1:0] rdata_r;
   logic              share_zero_s;
   logic              grant_s;

   core_share_counter #(
      .LOAD_VAL (MIN_CORE_CYCLES),
      .CNT_W    (CNT_W)
   ) u_share_cnt (
      .clock (clock),
      .reset (reset),
      .load  (state_r == ST_ACK),
      .dec   (state_r == ST_IDLE),
      .zero  (share_zero_s)
   );

   assign grant_s = (state_r == ST_IDLE) && hif.host_req && share_zero_s;

   // Next-state decode; every non-idle state advances unconditionally.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) state_nx_s = ST_DRAIN;
            else         state_nx_s = ST_IDLE;
         end
         ST_DRAIN: state_nx_s = ST_HOST;
         ST_HOST:  state_nx_s = ST_ACK;
         ST_ACK:   state_nx_s = ST_IDLE;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // State, latched host request and host read-data capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         txn_r   <= '{we: 1'b0, addr: {REG_ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
         rdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         if (grant_s) begin
            txn_r <= '{we: hif.host_we, addr: hif.host_reg, wdata: hif.host_wdata};
         end else begin
            txn_r <= txn_r;
         end
         // Read port is sampled before the write lands, so host writes return old contents.
         if (state_r == ST_HOST) begin
            rdata_r <= rf_rdataA;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   // Register-file port mux: the host takes the port only during its access cycle.
   always_comb begin
      rf_we    = core_we;
      rf_wreg  = core_wreg;
      rf_wdata = core_wdata;
      rf_rregA = core_rregA;
      rf_rregB = core_rregB;
      if (state_r == ST_HOST) begin
         // r0 is hardwired zero; a reset in this cycle aborts the host write.
         rf_we    = txn_r.we && (txn_r.addr != {REG_ADDR_W{1'b0}}) && !reset;
         rf_wreg  = txn_r.addr;
         rf_wdata = txn_r.wdata;
         rf_rregA = txn_r.addr;
      end else begin
         rf_rregB = core_rregB;
      end
   end

   assign core_rdataA    = rf_rdataA;
   assign core_rdataB    = rf_rdataB;
   assign core_stall     = (state_r == ST_DRAIN) || (state_r == ST_HOST);
   assign hif.host_ack   = (state_r == ST_ACK);
   assign hif.host_rdata = rdata_r;

endmodule

// File: tb/tb_regfile_host_arbiter.sv
// Directed bench for regfile_host_arbiter with a behavioural register file attached.
module tb_regfile_host_arbiter;
   import regfile_arb_pkg::*;

   localparam int MIN_CC = 4;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  core_we;
   logic [REG_ADDR_W-1:0] core_wreg;
   logic [DATA_W-1:0]     core_wdata;
   logic [REG_ADDR_W-1:0] core_rregA, core_rregB;
   logic [DATA_W-1:0]     core_rdataA, core_rdataB;
   logic                  core_stall;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_wreg, rf_rregA, rf_rregB;
   logic [DATA_W-1:0]     rf_wdata, rf_rdataA, rf_rdataB;
   logic [DATA_W-1:0]     mem [0:31];

   int n_vec  = 0;
   int n_miss = 0;

   regfile_host_arbiter_if hif();

   regfile_host_arbiter #(.MIN_CORE_CYCLES(MIN_CC)) dut (
      .clock       (clock),
      .reset       (reset),
      .hif         (hif),
      .core_we     (core_we),
      .core_wreg   (core_wreg),
      .core_wdata  (core_wdata),
      .core_rregA  (core_rregA),
      .core_rregB  (core_rregB),
      .core_rdataA (core_rdataA),
      .core_rdataB (core_rdataB),
      .core_stall  (core_stall),
      .rf_we       (rf_we),
      .rf_wreg     (rf_wreg),
      .rf_wdata    (rf_wdata),
      .rf_rregA    (rf_rregA),
      .rf_rregB    (rf_rregB),
      .rf_rdataA   (rf_rdataA),
      .rf_rdataB   (rf_rdataB)
   );

   always #5 clock = ~clock;

   // Register file stores every write, r0 included, so a stray r0 write is visible.
   always @(posedge clock) begin
      if (rf_we) mem[rf_wreg] <= rf_wdata;
   end
   assign rf_rdataA = mem[rf_rregA];
   assign rf_rdataB = mem[rf_rregB];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      core_we = 1'b0;
      repeat (n) tick();
   endtask

   // Holds host_req until host_ack (bounded), then releases it in the ack cycle.
   task automatic host_txn(input logic we, input logic [4:0] r, input logic [31:0] d,
                           output int ack_at, output int stalls, output int wes);
      hif.host_req = 1'b1; hif.host_we = we; hif.host_reg = r; hif.host_wdata = d;
      ack_at = -1; stalls = 0; wes = 0;
      for (int i = 1; i <= 20 && ack_at < 0; i++) begin
         tick();
         stalls += int'(core_stall);
         wes    += int'(rf_we);
         if (hif.host_ack) begin
            ack_at = i;
            hif.host_req = 1'b0;
         end
      end
      hif.host_req = 1'b0;
   endtask

   initial begin
      int ack_at, stalls, wes, a1, a2, n_ack, gap_st, early_st;
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      reset = 1'b1; core_we = 1'b0; core_wreg = 5'd0; core_wdata = 32'd0;
      core_rregA = 5'd0; core_rregB = 5'd0;
      hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_reg = 5'd0; hif.host_wdata = 32'd0;
      tick(); tick();
      chk("rst_stall", 32'(core_stall), 32'd0);
      chk("rst_ack",   32'(hif.host_ack), 32'd0);
      chk("rst_rdata", hif.host_rdata, 32'd0);
      reset = 1'b0;

      // Core writes r13=25 then reads it back through the idle pass-through.
      core_we = 1'b1; core_wreg = 5'd13; core_wdata = 32'd25;
      tick();
      core_we = 1'b0; core_rregA = 5'd13;
      #1;
      chk("idle_rdA", core_rdataA, 32'd25);
      idle(1);

      host_txn(1'b0, 5'd13, 32'd0, ack_at, stalls, wes);
      chk("rd_ack_lat", 32'(ack_at), 32'd3);
      chk("rd_stalls",  32'(stalls), 32'd2);
      chk("rd_rfwe",    32'(wes), 32'd0);
      chk("rd_rdata",   hif.host_rdata, 32'd25);
      tick();
      chk("ack_one_cycle", 32'(hif.host_ack), 32'd0);
      chk("stall_after",   32'(core_stall), 32'd0);
      idle(5);
      chk("rdata_hold", hif.host_rdata, 32'd25);

      host_txn(1'b1, 5'd7, 32'd40, ack_at, stalls, wes);
      chk("wr_ack_lat", 32'(ack_at), 32'd3);
      chk("wr_rfwe",    32'(wes), 32'd1);
      chk("wr_rdata_old", hif.host_rdata, 32'd0);
      idle(6);
      core_rregA = 5'd7; core_rregB = 5'd13;
      #1;
      chk("r7_after_wr", core_rdataA, 32'd40);
      chk("r13_portB",   core_rdataB, 32'd25);

      host_txn(1'b1, 5'd0, 32'hFFFF_FFFF, ack_at, stalls, wes);
      chk("r0_ack_lat", 32'(ack_at), 32'd3);
      chk("r0_rfwe",    32'(wes), 32'd0);
      idle(6);
      core_rregA = 5'd0;
      #1;
      chk("r0_reads_0", core_rdataA, 32'd0);

      // Continuous request: pulses 8 cycles apart, core owns the file in between.
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_reg = 5'd13;
      a1 = -1; a2 = -1; n_ack = 0; gap_st = 0; early_st = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (hif.host_ack) begin
            n_ack++;
            if (a1 < 0) a1 = i;
            else if (a2 < 0) a2 = i;
         end
         if (a1 >= 0 && i > a1 && i <= a1 + MIN_CC + 3) gap_st += int'(core_stall);
         if (a1 >= 0 && i > a1 && i <= a1 + MIN_CC + 1) early_st += int'(core_stall);
      end
      hif.host_req = 1'b0;
      chk("cont_first_ack", 32'(a1), 32'd3);
      chk("cont_spacing",   32'(a2 - a1), 32'(MIN_CC + 4));
      chk("cont_n_ack",     32'(n_ack), 32'd5);
      chk("cont_gap_free",  32'(early_st), 32'd0);
      chk("cont_gap_stall", 32'(gap_st), 32'd2);
      idle(8);

      // Core write r3=8 on the grant edge, in-flight writeback r4=8 during DRAIN.
      core_we = 1'b1; core_wreg = 5'd3; core_wdata = 32'd8;
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_reg = 5'd3;
      tick();
      chk("drain_stall", 32'(core_stall), 32'd1);
      chk("drain_rfwe",  32'(rf_we), 32'd1);
      core_wreg = 5'd4;
      tick();
      core_we = 1'b0;
      chk("host_rfwe_rd", 32'(rf_we), 32'd0);
      tick();
      hif.host_req = 1'b0;
      chk("drain_ack", 32'(hif.host_ack), 32'd1);
      chk("drain_rdata_r3", hif.host_rdata, 32'd8);
      idle(1);
      core_rregA = 5'd3; core_rregB = 5'd4;
      #1;
      chk("r3_reads_8", core_rdataA, 32'd8);
      chk("r4_drain_wr", core_rdataB, 32'd8);
      idle(8);

      // Reset during HOST aborts a write to r5.
      hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_reg = 5'd5; hif.host_wdata = 32'h55;
      tick(); tick();
      chk("abort_in_host", 32'(core_stall), 32'd1);
      reset = 1'b1; hif.host_req = 1'b0;
      tick();
      chk("abort_stall", 32'(core_stall), 32'd0);
      chk("abort_ack",   32'(hif.host_ack), 32'd0);
      chk("abort_rdata", hif.host_rdata, 32'd0);
      reset = 1'b0;
      n_ack = 0; wes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_ack += int'(hif.host_ack);
         wes   += int'(rf_we);
      end
      chk("abort_no_ack", 32'(n_ack), 32'd0);
      chk("abort_no_we",  32'(wes), 32'd0);
      core_rregA = 5'd5;
      #1;
      chk("abort_r5", core_rdataA, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
